// File: rtl/key_note_scheduler.sv
// Round-robin note scheduler: synchronizes and debounces the key pads, then time-shares one tone generator across held keys.
// Optional debounce stage selected by KEY_DEBOUNCE_EN; undefined, held_keys is the raw synchronizer output.
module key_note_scheduler #(
    parameter int SLOT_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [11:0] keys_in,
    input  logic [3:0]  octave_in,
    output logic [3:0]  note_idx,
    output logic [3:0]  note_octave,
    output logic        note_valid,
    output logic        note_start,
    output logic [11:0] held_keys
);

    localparam int SW = $clog2(SLOT_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    logic [11:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] db_cnt;
    logic [11:0]   held_q;

    // sync1 is what sync2 samples next, so a mismatch flags the change one
    // edge early; this lines the copy up at 2 + DEBOUNCE_CYCLES after the input edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            held_q <= '0;
        end else if (sync1 != sync2) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            held_q <= sync2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign held_keys = held_q;
`else
    assign held_keys = sync2;

    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_unused
    end
`endif

    state_t        state, state_nxt;
    logic [SW-1:0] slot_cnt, slot_nxt;
    logic [3:0]    idx_nxt, oct_nxt;
    logic          valid_nxt, start_nxt;

    logic [3:0] low_idx, above_idx, next_idx, oct_clamped;
    logic       low_found, above_found, cur_held;

    assign oct_clamped = (octave_in > 4'd8) ? 4'd8 : octave_in;
    assign cur_held    = |(held_keys & (12'b1 << note_idx));

    always_comb begin
        low_idx     = '0;
        above_idx   = '0;
        low_found   = 1'b0;
        above_found = 1'b0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (held_keys[i] && !low_found) begin
                low_idx   = 4'(i);
                low_found = 1'b1;
            end
            if (held_keys[i] && !above_found && (i > 32'(note_idx))) begin
                above_idx   = 4'(i);
                above_found = 1'b1;
            end
        end
        next_idx = above_found ? above_idx : low_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            slot_cnt    <= '0;
            note_idx    <= '0;
            note_octave <= '0;
            note_valid  <= 1'b0;
            note_start  <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot_cnt    <= slot_nxt;
            note_idx    <= idx_nxt;
            note_octave <= oct_nxt;
            note_valid  <= valid_nxt;
            note_start  <= start_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt;
        idx_nxt   = note_idx;
        oct_nxt   = note_octave;
        valid_nxt = note_valid;
        start_nxt = 1'b0;
        if (!ena) begin
            state_nxt = S_IDLE;
            slot_nxt  = '0;
            idx_nxt   = '0;
            oct_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    slot_nxt  = '0;
                    valid_nxt = 1'b0;
                    if (held_keys != '0) begin
                        state_nxt = S_PLAY;
                        idx_nxt   = low_idx;
                        oct_nxt   = oct_clamped;
                        valid_nxt = 1'b1;
                        start_nxt = 1'b1;
                    end
                end
                S_PLAY: begin
                    valid_nxt = 1'b1;
                    // Release wins over slot expiry; either way only one advance happens.
                    if (!cur_held) begin
                        slot_nxt = '0;
                        if (held_keys == '0) begin
                            state_nxt = S_IDLE;
                            valid_nxt = 1'b0;
                        end else begin
                            idx_nxt   = next_idx;
                            oct_nxt   = oct_clamped;
                            start_nxt = 1'b1;
                        end
                    end else if (slot_cnt == SLOT_LAST) begin
                        slot_nxt = '0;
                        if (next_idx != note_idx || oct_clamped != note_octave) begin
                            idx_nxt   = next_idx;
                            oct_nxt   = oct_clamped;
                            start_nxt = 1'b1;
                        end
                    end else begin
                        slot_nxt = slot_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_note_scheduler.sv
// Self-checking bench for key_note_scheduler: note_start strobes are matched against a scoreboard of expected loads.
module tb_key_note_scheduler;

    localparam int SLOT = 8;
    localparam int DEB  = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned LAT   = 2 + DEB;
    localparam bit          DB_ON = 1'b1;
`else
    localparam int unsigned LAT   = 2;
    localparam bit          DB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ena;
    logic [11:0] keys_in;
    logic [3:0]  octave_in;
    logic [3:0]  note_idx, note_octave;
    logic        note_valid, note_start;
    logic [11:0] held_keys;

    typedef struct {
        logic [3:0]  idx;
        logic [3:0]  oct;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    key_note_scheduler #(.SLOT_CYCLES(SLOT), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .ena(ena), .keys_in(keys_in), .octave_in(octave_in),
        .note_idx(note_idx), .note_octave(note_octave), .note_valid(note_valid),
        .note_start(note_start), .held_keys(held_keys)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expected load exactly in index, octave and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (note_start === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_start: idx=%0d oct=%0d cyc=%0d, expected no strobe", note_idx, note_octave, cyc);
            end else begin
                e = exp_q.pop_front();
                if (note_idx !== e.idx || note_octave !== e.oct || cyc !== e.at) begin
                    miscompares++;
                    $display("FAIL start_match: got idx=%0d oct=%0d cyc=%0d, expected idx=%0d oct=%0d cyc=%0d",
                             note_idx, note_octave, cyc, e.idx, e.oct, e.at);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cyc=%0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] i, input logic [3:0] o, input int unsigned t);
        exp_t e;
        e.idx = i;
        e.oct = o;
        e.at  = t;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1; ena = 1'b1; keys_in = '0; octave_in = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({note_idx, note_octave, note_valid, note_start, held_keys} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_state: got idx=%0d oct=%0d valid=%b start=%b held=%h, expected all 0",
                     note_idx, note_octave, note_valid, note_start, held_keys);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int unsigned c0, t0;
        keys_in = 12'h010; octave_in = 4'd4;
        c0 = cyc; t0 = c0 + LAT + 1;
        push(4'd4, 4'd4, t0);
        wait_until(c0 + LAT - 1);
        vectors++;
        if (held_keys !== 12'h000) begin
            miscompares++;
            $display("FAIL single_held_early: got %h, expected 000", held_keys);
        end
        wait_until(c0 + LAT);
        vectors++;
        if (held_keys !== 12'h010) begin
            miscompares++;
            $display("FAIL single_held: got %h, expected 010", held_keys);
        end
        wait_until(t0);
        vectors++;
        if (note_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_valid: got %b, expected 1", note_valid);
        end
        // Two slot expiries with an unchanged note must stay silent; then an octave change re-strobes.
        wait_until(t0 + 2 * SLOT);
        octave_in = 4'd5;
        push(4'd4, 4'd5, t0 + 3 * SLOT);
        wait_until(t0 + 3 * SLOT);
        keys_in = '0;
        wait_until(t0 + 3 * SLOT + LAT);
        vectors++;
        if (note_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_valid_before_release: got %b, expected 1", note_valid);
        end
        wait_until(t0 + 3 * SLOT + LAT + 1);
        vectors++;
        if (note_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_valid_after_release: got %b, expected 0", note_valid);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_missing_start: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_arpeggio;
        int unsigned c0, t0;
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd2, 4'd11, 4'd0, 4'd2};
        keys_in = 12'h805; octave_in = 4'd4;
        c0 = cyc; t0 = c0 + LAT + 1;
        for (int unsigned k = 0; k < 5; k++) push(seq[k], 4'd4, t0 + k * SLOT);
        wait_until(t0 + 4 * SLOT);
        keys_in = '0;
        wait_until(t0 + 4 * SLOT + LAT + 1);
        vectors++;
        if (note_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arpeggio_idle: got valid=%b, expected 0", note_valid);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL arpeggio_missing_start: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_release;
        int unsigned c0, t0;
        keys_in = 12'h005; octave_in = 4'd4;
        c0 = cyc; t0 = c0 + LAT + 1;
        push(4'd0, 4'd4, t0);
        wait_until(t0);
        keys_in = 12'h004;
        push(4'd2, 4'd4, t0 + LAT + 1);
        wait_until(t0 + LAT);
        vectors++;
        if (held_keys !== 12'h004 || note_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL release_held: got held=%h idx=%0d, expected held=004 idx=0", held_keys, note_idx);
        end
        wait_until(t0 + LAT + 1);
        vectors++;
        if (note_idx !== 4'd2) begin
            miscompares++;
            $display("FAIL release_advance: got idx=%0d, expected 2", note_idx);
        end
        keys_in = '0;
        wait_until(t0 + 2 * LAT + 1);
        vectors++;
        if (note_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL release_valid_hold: got %b, expected 1", note_valid);
        end
        wait_until(t0 + 2 * LAT + 2);
        vectors++;
        if (note_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL release_all_idle: got %b, expected 0", note_valid);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL release_missing_start: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clamp_disable;
        int unsigned c0, t0, t1;
        keys_in = 12'h002; octave_in = 4'd13;
        c0 = cyc; t0 = c0 + LAT + 1;
        push(4'd1, 4'd8, t0);
        wait_until(t0);
        ena = 1'b0;
        wait_until(t0 + 1);
        vectors++;
        if (note_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL disable_valid: got %b, expected 0", note_valid);
        end
        keys_in = 12'h003;
        wait_until(t0 + LAT);
        vectors++;
        if (held_keys !== 12'h002) begin
            miscompares++;
            $display("FAIL disable_held_before: got %h, expected 002", held_keys);
        end
        wait_until(t0 + LAT + 1);
        vectors++;
        if (held_keys !== 12'h003 || note_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL disable_tracking: got held=%h valid=%b, expected held=003 valid=0", held_keys, note_valid);
        end
        ena = 1'b1; octave_in = 4'd9;
        t1 = t0 + LAT + 2;
        push(4'd0, 4'd8, t1);
        push(4'd1, 4'd8, t1 + SLOT);
        wait_until(t1 + SLOT);
        keys_in = '0;
        wait_until(t1 + SLOT + LAT + 1);
        vectors++;
        if (note_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_idle: got valid=%b, expected 0", note_valid);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL clamp_missing_start: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_debounce;
        int unsigned c0;
        logic [11:0] exp_held;
        logic        exp_valid;
        octave_in = 4'd2;
        c0 = cyc;
        keys_in = 12'h080;
        if (!DB_ON) push(4'd7, 4'd2, c0 + 3);
        for (int unsigned k = c0 + 1; k <= c0 + 12; k++) begin
            wait_until(k);
            exp_held  = (!DB_ON && k >= c0 + 2 && k <= c0 + 4) ? 12'h080 : 12'h000;
            exp_valid = !DB_ON && k >= c0 + 3 && k <= c0 + 5;
            vectors++;
            if (held_keys !== exp_held || note_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL glitch_cyc%0d: got held=%h valid=%b, expected held=%h valid=%b",
                         k - c0, held_keys, note_valid, exp_held, exp_valid);
            end
            if (k == c0 + 3) keys_in = '0;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_missing_start: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_note;
        int unsigned c0, t0;
        keys_in = 12'h100; octave_in = 4'd3;
        c0 = cyc; t0 = c0 + LAT + 1;
        push(4'd8, 4'd3, t0);
        wait_until(t0 + 3);
        rst = 1'b1; keys_in = '0;
        wait_until(t0 + 4);
        vectors++;
        if ({note_idx, note_octave, note_valid, note_start, held_keys} !== 22'h0) begin
            miscompares++;
            $display("FAIL midnote_reset: got idx=%0d oct=%0d valid=%b start=%b held=%h, expected all 0",
                     note_idx, note_octave, note_valid, note_start, held_keys);
        end
        wait_until(t0 + 5);
        rst = 1'b0;
        wait_until(t0 + 17);
        vectors++;
        if (note_valid !== 1'b0 || held_keys !== 12'h000) begin
            miscompares++;
            $display("FAIL midnote_after: got valid=%b held=%h, expected valid=0 held=000", note_valid, held_keys);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midnote_missing_start: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_arpeggio;
        test_release;
        test_clamp_disable;
        test_debounce;
        test_reset_mid_note;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_note_scheduler.md
# key_note_scheduler

Note scheduler between the 12-key/4-bit-octave pad inputs and the single tone generator of the simple piano. It conditions the raw key vector, then time-shares the one tone generator among all held keys round-robin (arpeggio), presenting one note index and one octave at a time. All outputs are registered; the tone generator consumes `note_idx`/`note_octave` while `note_valid` is high.

## Interface
- `SLOT_CYCLES`, 50000: cycles each held note owns the generator (50 ms at 1 MHz); minimum 2.
- `DEBOUNCE_CYCLES`, 5000: cycles the synchronized key vector must stay unchanged before it is accepted; minimum 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  block enable; low forces idle.
- `keys_in`  in  12  raw key levels, bit i = note index i, 1 = pressed.
- `octave_in`  in  4  requested octave, 0–15.
- `note_idx`  out  4  current note index 0–11.
- `note_octave`  out  4  octave for current note, 0–8.
- `note_valid`  out  1  a note is being played.
- `note_start`  out  1  one-cycle strobe when a new note index or octave is loaded.
- `held_keys`  out  12  debounced key vector (status).

## Operation
- Input path: `keys_in` → 2-flop synchronizer → debounce stage → `held_keys`.
- Debounce (shared, not per key): a counter restarts whenever the synchronized vector differs from the previous cycle's sample. After `DEBOUNCE_CYCLES` consecutive cycles with no change, the vector is copied to `held_keys`.
- Octave clamp: values 9–15 are treated as 8. The clamped octave is sampled into `note_octave` only when a note is loaded.
- FSM states:
  - IDLE: `note_valid`=0, slot counter=0. If `held_keys`≠0, load the lowest set index, pulse `note_start`, and go to PLAY.
  - PLAY: the slot counter increments each cycle. At `SLOT_CYCLES`-1 the counter wraps to 0 and the next note is picked.
- Next note: the lowest set index strictly greater than `note_idx`; if none, wrap to the lowest set index overall.
- Same-note rule: if the picked index equals the current index and the clamped octave is unchanged, there is no `note_start` and the note continues.
- Current key released in PLAY (bit `note_idx` of `held_keys` = 0): on the next cycle, advance to the next note by the rule above and restart the slot counter. If `held_keys`=0, go to IDLE instead.
- Simultaneous events: release takes priority over slot expiry; both produce a single advance.
- `ena`=0: behaves as reset for the FSM and slot counter. The synchronizer and debounce keep running, so `held_keys` stays current.

## Timing
- Reset values: `note_idx`=0, `note_octave`=0, `note_valid`=0, `note_start`=0, `held_keys`=0, FSM=IDLE, all counters 0.
- Key to `held_keys` latency: 2 sync cycles + `DEBOUNCE_CYCLES` from the last input change (macro defined).
- `held_keys` becoming nonzero → `note_valid`/`note_start` high on the next cycle.
- In steady PLAY, consecutive loads are exactly `SLOT_CYCLES` apart.
- Release → next note loaded 1 cycle after `held_keys` drops the bit.
- `note_start` is high in exactly the cycle `note_idx`/`note_octave` first show the new value.
- Reset asserted mid-note: all outputs return to reset values on the next edge, and no `note_start` is issued.

## Configuration
- `KEY_DEBOUNCE_EN` defined: the debounce stage is present as described.
- `KEY_DEBOUNCE_EN` undefined: the debounce stage is removed and `held_keys` equals the synchronizer output. Key-to-`held_keys` latency becomes 2 cycles and `DEBOUNCE_CYCLES` is ignored.

## Test plan
All cases use `SLOT_CYCLES`=8, `DEBOUNCE_CYCLES`=4, macro defined unless noted.
- Reset: assert `rst` during PLAY → next cycle all outputs 0, FSM idle, `held_keys`=0.
- Single key: `keys_in`=12'h010, `octave_in`=4 → `held_keys`=12'h010 after 6 cycles. Next cycle: `note_valid`=1, `note_idx`=4, `note_octave`=4, one `note_start`, and no further `note_start` while held.
- Arpeggio: `keys_in`=12'h805 → notes 0, 2, 11, 0, … with each `note_start` 8 cycles apart.
- Release: hold 12'h005 while playing idx 0, then change to 12'h004 → `note_idx`=2 one cycle after `held_keys` updates. Then 12'h000 → `note_valid`=0.
- Clamp and disable: `octave_in`=13 → `note_octave`=8. `ena`=0 mid-note → `note_valid`=0 next cycle while `held_keys` keeps tracking.
- Debounce: 3-cycle glitch on bit 7 → `held_keys` unchanged. With the macro undefined, the same glitch appears in `held_keys` 2 cycles later.
